// File: rtl/sargantana_icache_refill_pkg.sv
// Shared types and sizing helpers for the icache refill writer.
// The beat count and the counter width are derived from the line and beat widths.
package sargantana_icache_refill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DRAIN = 2'd3
  } refill_state_t;

  function automatic int unsigned calc_beats(input int unsigned set_w, input int unsigned beat_w);
    return set_w / beat_w;
  endfunction

  function automatic int unsigned calc_cnt_width(input int unsigned beats);
    return (beats > 32'd1) ? $clog2(beats) : 32'd1;
  endfunction

endpackage

// File: rtl/sargantana_icache_line_assembler.sv
// Beat counter and line slot register: each load drops one beat into the next slot.
// line_next_o exposes the line including the beat being loaded this cycle.
module sargantana_icache_line_assembler
  import sargantana_icache_refill_pkg::*;
#(
  parameter int unsigned SET_WIDHT  = 256,
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned BEATS      = calc_beats(SET_WIDHT, BEAT_WIDTH),
  parameter int unsigned CNT_W      = calc_cnt_width(BEATS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [BEAT_WIDTH-1:0] beat_data_i,
  output logic                  full_o,
  output logic [SET_WIDHT-1:0]  line_next_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SET_WIDHT-1:0] line_q, line_d;

  // Next counter/line: clear wins over load, the counter wraps after the last slot
  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (clear_i) begin
      cnt_d  = '0;
      line_d = '0;
    end else if (load_i) begin
      line_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = beat_data_i;
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d  = cnt_q;
      line_d = line_q;
    end
  end

  // Counter and line registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign full_o      = (cnt_q == LAST_CNT);
  assign line_next_o = line_d;

endmodule

// File: rtl/sargantana_icache_refill_writer.sv
// Collects an L2 refill beat stream into a full line and writes it to one icache way.
// Memory-side outputs come straight from registers; req_o/we_o decode only the state.
module sargantana_icache_refill_writer
  import sargantana_icache_refill_pkg::*;
#(
  parameter int unsigned ICACHE_N_WAY = 4,
  parameter int unsigned SET_WIDHT    = 256,
  parameter int unsigned ADDR_WIDHT   = 6,
  parameter int unsigned BEAT_WIDTH   = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            refill_valid_i,
  output logic                            refill_ready_o,
  input  logic [ADDR_WIDHT-1:0]           refill_addr_i,
  input  logic [$clog2(ICACHE_N_WAY)-1:0] refill_way_i,
  input  logic                            beat_valid_i,
  output logic                            beat_ready_o,
  input  logic [BEAT_WIDTH-1:0]           beat_data_i,
  input  logic                            beat_last_i,
  input  logic                            abort_i,
  input  logic                            mem_gnt_i,
  output logic [ICACHE_N_WAY-1:0]         req_o,
  output logic                            we_o,
  output logic [ADDR_WIDHT-1:0]           addr_o,
  output logic [SET_WIDHT-1:0]            data_o,
  output logic                            done_o,
  output logic                            err_o,
  output logic                            busy_o
);

  localparam int unsigned BEATS = calc_beats(SET_WIDHT, BEAT_WIDTH);
  localparam int unsigned CNT_W = calc_cnt_width(BEATS);
  localparam logic [ICACHE_N_WAY-1:0] WAY_ONE = {{(ICACHE_N_WAY-1){1'b0}}, 1'b1};

  refill_state_t           state_q, state_d;
  logic [ADDR_WIDHT-1:0]   addr_q, addr_d;
  logic [ICACHE_N_WAY-1:0] way_oh_q, way_oh_d;
  logic [ADDR_WIDHT-1:0]   out_addr_q, out_addr_d;
  logic [SET_WIDHT-1:0]    out_data_q, out_data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    init_q;

  logic                    asm_clear, asm_load, asm_full;
  logic [SET_WIDHT-1:0]    asm_line_next;
  logic                    cmd_fire, beat_fire;

  sargantana_icache_line_assembler #(
    .SET_WIDHT  (SET_WIDHT),
    .BEAT_WIDTH (BEAT_WIDTH),
    .BEATS      (BEATS),
    .CNT_W      (CNT_W)
  ) u_line_assembler (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (asm_clear),
    .load_i      (asm_load),
    .beat_data_i (beat_data_i),
    .full_o      (asm_full),
    .line_next_o (asm_line_next)
  );

  // init_q keeps refill_ready_o low for the cycle in which reset is released
  assign refill_ready_o = (state_q == IDLE) && init_q;
  assign beat_ready_o   = (state_q == FILL) || (state_q == DRAIN);
  assign cmd_fire       = refill_valid_i && refill_ready_o;
  assign beat_fire      = beat_valid_i && beat_ready_o;

  // Next-state and register-update decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    way_oh_d   = way_oh_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    asm_clear  = 1'b0;
    asm_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          addr_d    = refill_addr_i;
          way_oh_d  = WAY_ONE << refill_way_i;
          asm_clear = 1'b1;
          state_d   = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (beat_fire) begin
          asm_load = 1'b1;
          if (abort_i) begin
            state_d = beat_last_i ? IDLE : DRAIN;
          end else if (beat_last_i && asm_full) begin
            out_addr_d = addr_q;
            out_data_d = asm_line_next;
            state_d    = WRITE;
          end else if (beat_last_i) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (asm_full) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = FILL;
          end
        end else if (abort_i) begin
          state_d = DRAIN;
        end else begin
          state_d = FILL;
        end
      end
      WRITE: begin
        // A grant in the same cycle as an abort still completes the write
        if (mem_gnt_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (abort_i) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      DRAIN: begin
        if (beat_fire && beat_last_i) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      way_oh_q   <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      way_oh_q   <= way_oh_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      init_q     <= 1'b1;
    end
  end

  assign req_o  = (state_q == WRITE) ? way_oh_q : '0;
  assign we_o   = (state_q == WRITE);
  assign addr_o = out_addr_q;
  assign data_o = out_data_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_sargantana_icache_refill_writer.sv
// Directed self-checking bench for the icache refill writer (default parameters).
module tb_sargantana_icache_refill_writer;

  logic         clk_i, rst_i;
  logic         refill_valid_i, refill_ready_o;
  logic [5:0]   refill_addr_i;
  logic [1:0]   refill_way_i;
  logic         beat_valid_i, beat_ready_o, beat_last_i;
  logic [63:0]  beat_data_i;
  logic         abort_i, mem_gnt_i;
  logic [3:0]   req_o;
  logic         we_o;
  logic [5:0]   addr_o;
  logic [255:0] data_o;
  logic         done_o, err_o, busy_o;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [255:0] line_a, line_b, line_c, line_d, line_e;

  sargantana_icache_refill_writer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o),
    .refill_addr_i(refill_addr_i), .refill_way_i(refill_way_i),
    .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o),
    .beat_data_i(beat_data_i), .beat_last_i(beat_last_i),
    .abort_i(abort_i), .mem_gnt_i(mem_gnt_i),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .data_o(data_o),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Count array writes actually performed (write enable together with grant)
  always @(posedge clk_i) begin
    if (we_o && mem_gnt_i) wr_cnt <= wr_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk_i);
  endtask

  task automatic send_cmd(input logic [5:0] a, input logic [1:0] w);
    refill_valid_i = 1'b1; refill_addr_i = a; refill_way_i = w;
    cycle();
    refill_valid_i = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    beat_valid_i = 1'b1; beat_data_i = d; beat_last_i = last;
    cycle();
    beat_valid_i = 1'b0; beat_last_i = 1'b0;
  endtask

  task automatic fill_line(input logic [5:0] a, input logic [1:0] w, input logic [255:0] line);
    send_cmd(a, w);
    for (int i = 0; i < 4; i++) send_beat(line[i*64 +: 64], (i == 3));
  endtask

  task automatic check_write(input string tag, input logic [3:0] r, input logic [5:0] a,
                             input logic [255:0] d);
    check_eq({tag, "_req"}, {252'd0, req_o}, {252'd0, r});
    check_eq({tag, "_we"}, {255'd0, we_o}, 256'd1);
    check_eq({tag, "_addr"}, {250'd0, addr_o}, {250'd0, a});
    check_eq({tag, "_data"}, data_o, d);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             {248'd0, refill_ready_o, beat_ready_o, req_o == 4'd0 ? 1'b0 : 1'b1, we_o,
              addr_o == 6'd0 ? 1'b0 : 1'b1, done_o, err_o, busy_o}, 256'd0);
    check_eq({tag, "_data"}, data_o, 256'd0);
  endtask

  initial begin
    line_a = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    line_b = {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2, 64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0};
    line_c = {64'hC3C3C3C3C3C3C3C3, 64'hC2C2C2C2C2C2C2C2, 64'hC1C1C1C1C1C1C1C1, 64'hC0C0C0C0C0C0C0C0};
    line_d = {64'hDEAD0003BEEF0003, 64'hDEAD0002BEEF0002, 64'hDEAD0001BEEF0001, 64'hDEAD0000BEEF0000};
    line_e = {64'hE3E3000000000E3E, 64'hE2E2000000000E2E, 64'hE1E1000000000E1E, 64'hE0E0000000000E0E};
    rst_i = 1'b1; refill_valid_i = 1'b0; refill_addr_i = 6'd0; refill_way_i = 2'd0;
    beat_valid_i = 1'b0; beat_data_i = 64'd0; beat_last_i = 1'b0; abort_i = 1'b0; mem_gnt_i = 1'b0;

    // Reset
    repeat (3) cycle();
    check_all_zero("reset");
    rst_i = 1'b0;
    cycle();
    check_eq("ready_after_reset", {255'd0, refill_ready_o}, 256'd1);

    // Basic refill, 5 cycles command-to-write
    send_cmd(6'h15, 2'd2);
    check_eq("fill_state", {253'd0, busy_o, beat_ready_o, refill_ready_o}, 256'b110);
    send_beat(line_a[63:0], 1'b0);
    send_beat(line_a[127:64], 1'b0);
    send_beat(line_a[191:128], 1'b0);
    check_eq("no_we_in_fill", {255'd0, we_o}, 256'd0);
    send_beat(line_a[255:192], 1'b1);
    check_write("basic", 4'b0100, 6'h15, line_a);
    check_eq("basic_beat_ready", {255'd0, beat_ready_o}, 256'd0);
    mem_gnt_i = 1'b1;
    cycle();
    mem_gnt_i = 1'b0;
    check_eq("basic_done", {254'd0, done_o, we_o}, 256'b10);
    check_eq("basic_wr_cnt", 256'(wr_cnt), 256'd1);
    check_eq("basic_data_hold", data_o, line_a);
    check_eq("basic_ready_next", {255'd0, refill_ready_o}, 256'd1);
    cycle();
    check_eq("basic_done_once", {255'd0, done_o}, 256'd0);

    // Grant stall: outputs stable for 4 cycles
    fill_line(6'h2A, 2'd1, line_b);
    for (int k = 0; k < 4; k++) begin
      check_write("stall", 4'b0010, 6'h2A, line_b);
      check_eq("stall_no_done", {255'd0, done_o}, 256'd0);
      if (k < 3) cycle();
    end
    mem_gnt_i = 1'b1;
    cycle();
    mem_gnt_i = 1'b0;
    check_eq("stall_done", {255'd0, done_o}, 256'd1);
    check_eq("stall_wr_cnt", 256'(wr_cnt), 256'd2);

    // Early last on beat 1
    send_cmd(6'h07, 2'd3);
    send_beat(64'h0000000000000001, 1'b0);
    send_beat(64'h0000000000000002, 1'b1);
    check_eq("early_err", {253'd0, err_o, busy_o, we_o}, 256'b100);
    check_eq("early_ready", {255'd0, refill_ready_o}, 256'd1);
    cycle();
    check_eq("early_err_pulse", {255'd0, err_o}, 256'd0);
    fill_line(6'h08, 2'd3, line_c);
    check_write("after_early", 4'b1000, 6'h08, line_c);
    mem_gnt_i = 1'b1;
    cycle();
    mem_gnt_i = 1'b0;
    check_eq("after_early_wr_cnt", 256'(wr_cnt), 256'd3);

    // Missing last on final beat: error then drain
    send_cmd(6'h01, 2'd0);
    for (int i = 0; i < 4; i++) send_beat(64'h5555, 1'b0);
    check_eq("nolast_err", {253'd0, err_o, busy_o, beat_ready_o}, 256'b111);
    send_beat(64'h6666, 1'b1);
    check_eq("nolast_drained", {253'd0, err_o, busy_o, refill_ready_o}, 256'b001);

    // Abort mid-fill, remaining beats drained
    send_cmd(6'h22, 2'd1);
    send_beat(64'h1, 1'b0);
    send_beat(64'h2, 1'b0);
    abort_i = 1'b1;
    cycle();
    abort_i = 1'b0;
    check_eq("abort_drain", {254'd0, busy_o, beat_ready_o}, 256'b11);
    send_beat(64'h3, 1'b0);
    send_beat(64'h4, 1'b1);
    check_eq("abort_idle", {252'd0, refill_ready_o, busy_o, we_o, err_o}, 256'b1000);
    check_eq("abort_wr_cnt", 256'(wr_cnt), 256'd3);

    // Abort together with a last beat goes straight to idle
    send_cmd(6'h23, 2'd1);
    abort_i = 1'b1;
    send_beat(64'h7, 1'b1);
    abort_i = 1'b0;
    check_eq("abort_last_idle", {253'd0, busy_o, err_o, refill_ready_o}, 256'b001);

    // Abort in WRITE without grant, then with grant
    fill_line(6'h30, 2'd2, line_d);
    abort_i = 1'b1;
    cycle();
    abort_i = 1'b0;
    check_eq("write_abort", {253'd0, busy_o, we_o, done_o}, 256'b000);
    cycle();
    check_eq("write_abort_no_done", {255'd0, done_o}, 256'd0);
    check_eq("write_abort_wr_cnt", 256'(wr_cnt), 256'd3);
    fill_line(6'h31, 2'd2, line_d);
    abort_i = 1'b1; mem_gnt_i = 1'b1;
    cycle();
    abort_i = 1'b0; mem_gnt_i = 1'b0;
    check_eq("abort_gnt_done", {255'd0, done_o}, 256'd1);
    check_eq("abort_gnt_wr_cnt", 256'(wr_cnt), 256'd4);

    // Reset mid-FILL, then a clean refill to way 0
    send_cmd(6'h11, 2'd1);
    send_beat(64'hBAD0, 1'b0);
    send_beat(64'hBAD1, 1'b0);
    rst_i = 1'b1;
    cycle();
    check_all_zero("mid_reset");
    rst_i = 1'b0;
    cycle();
    check_eq("mid_reset_ready", {255'd0, refill_ready_o}, 256'd1);
    fill_line(6'h3F, 2'd0, line_e);
    check_write("post_reset", 4'b0001, 6'h3F, line_e);
    mem_gnt_i = 1'b1;
    cycle();
    mem_gnt_i = 1'b0;
    check_eq("post_reset_done", {255'd0, done_o}, 256'd1);
    check_eq("post_reset_wr_cnt", 256'(wr_cnt), 256'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
